pll_drp_ctrl: RTL and testbench

PLL_DRP_CTRL -- requirements
Module: pll_drp_ctrl

---
 rtl/pll_drp_ctrl.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_pll_drp_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_drp_ctrl.sv
// ---------------------------------------------------------------------------
// pll_drp_ctrl
//   Command front end for a PLL MDRP (mini dynamic reconfiguration port).
//   Reads and writes PLL configuration registers through an auto-increment
//   address port, and runs the PLL reset / relock ("apply") sequence, both
//   automatically after reset and on request. The PLL mdclk is driven from
//   clk at the top level, so the MDRP signals here are in the clk domain.
//
// Ports
//   clk, reset        system clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o, cmd_op_i (00 rd, 01 wr, 10 apply, 11 rsvd),
//   cmd_addr_i, cmd_wdata_i          command in (no queueing, one at a time)
//   rsp_valid_o, rsp_rdata_o, rsp_err_o   one-cycle response, no backpressure
//   mdopc_o, mdainc_o, mdwdi_o, mdrdo_i   PLL MDRP port
//   pll_reset_o, pll_lock_i (async)       PLL reset / lock
//   init_done_o       power-up apply sequence finished
//   lock_err_o        sticky: some apply sequence timed out waiting for lock
// ---------------------------------------------------------------------------
module pll_drp_ctrl #(
    parameter int RD_LAT       = 2,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_op_i,
    input  logic [5:0] cmd_addr_i,
    input  logic [7:0] cmd_wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic       rsp_err_o,
    output logic [1:0] mdopc_o,
    output logic       mdainc_o,
    output logic [7:0] mdwdi_o,
    input  logic [7:0] mdrdo_i,
    output logic       pll_reset_o,
    input  logic       pll_lock_i,
    output logic       init_done_o,
    output logic       lock_err_o
);

    localparam int CMAX = (RST_CYCLES > RD_LAT) ? RST_CYCLES : RD_LAT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int TW   = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [1:0] OPC_NOP = 2'b00;
    localparam logic [1:0] OPC_WR  = 2'b01;
    localparam logic [1:0] OPC_RD  = 2'b10;

    typedef enum logic [3:0] {
        INIT_RST, INIT_WAIT, IDLE, SEEK_HI, SEEK_LO,
        ACC_WR, ACC_RD, RD_WAIT, APP_RST, APP_WAIT, RESP
    } state_e;

    state_e          state_q;
    logic [5:0]      ptr_q;       // shadow of the PLL's internal MDRP address
    logic [5:0]      addr_q;
    logic [7:0]      wdata_q;
    logic            is_wr_q;
    logic            resv_q;      // reserved op: one extra RESP cycle, valid low
    logic [CW-1:0]   cnt_q;
    logic [TW-1:0]   tcnt_q;
    logic            lock_meta_q, lock_s_q;

    logic [1:0]      mdopc_q;
    logic            mdainc_q;
    logic [7:0]      mdwdi_q;
    logic            pll_reset_q;
    logic            rsp_valid_q;
    logic [7:0]      rsp_rdata_q;
    logic            rsp_err_q;
    logic            cmd_ready_q;
    logic            init_done_q;
    logic            lock_err_q;

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign mdopc_o     = mdopc_q;
    assign mdainc_o    = mdainc_q;
    assign mdwdi_o     = mdwdi_q;
    assign pll_reset_o = pll_reset_q;
    assign init_done_o = init_done_q;
    assign lock_err_o  = lock_err_q;

    // pll_lock comes straight from the PLL analog side
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock_i;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT_RST;
            ptr_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            is_wr_q     <= 1'b0;
            resv_q      <= 1'b0;
            cnt_q       <= '0;
            tcnt_q      <= '0;
            mdopc_q     <= OPC_NOP;
            mdainc_q    <= 1'b0;
            mdwdi_q     <= '0;
            pll_reset_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            init_done_q <= 1'b0;
            lock_err_q  <= 1'b0;
        end else begin
            case (state_q)
                // First cycle after reset arms pll_reset; later cycles time
                // the pulse exactly like APP_RST.
                INIT_RST: begin
                    if (!pll_reset_q) begin
                        pll_reset_q <= 1'b1;
                        ptr_q       <= '0;
                        cnt_q       <= '0;
                    end else if (cnt_q == CW'(RST_CYCLES - 1)) begin
                        pll_reset_q <= 1'b0;
                        tcnt_q      <= '0;
                        state_q     <= INIT_WAIT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                INIT_WAIT: begin
                    if (lock_s_q) begin
                        init_done_q <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (tcnt_q == TW'(LOCK_TIMEOUT - 1)) begin
                        init_done_q <= 1'b1;
                        lock_err_q  <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (tcnt_q != '1) begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end

                IDLE: begin
                    if (cmd_valid_i && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        addr_q      <= cmd_addr_i;
                        wdata_q     <= cmd_wdata_i;
                        is_wr_q     <= cmd_op_i[0];
                        case (cmd_op_i)
                            2'b00, 2'b01: begin
                                if (cmd_addr_i == ptr_q) begin
                                    if (cmd_op_i[0]) begin
                                        mdopc_q <= OPC_WR;
                                        mdwdi_q <= cmd_wdata_i;
                                        state_q <= ACC_WR;
                                    end else begin
                                        mdopc_q <= OPC_RD;
                                        state_q <= ACC_RD;
                                    end
                                end else begin
                                    mdainc_q <= 1'b1;
                                    state_q  <= SEEK_HI;
                                end
                            end
                            2'b10: begin
                                // PLL reset also returns its MDRP address to 0
                                pll_reset_q <= 1'b1;
                                ptr_q       <= '0;
                                cnt_q       <= '0;
                                state_q     <= APP_RST;
                            end
                            default: begin
                                // Reserved: spend one decode cycle in RESP so
                                // the response lands two cycles after accept.
                                resv_q      <= 1'b1;
                                rsp_err_q   <= 1'b1;
                                rsp_rdata_q <= '0;
                                state_q     <= RESP;
                            end
                        endcase
                    end
                end

                SEEK_HI: begin
                    mdainc_q <= 1'b0;
                    ptr_q    <= ptr_q + 6'd1;
                    state_q  <= SEEK_LO;
                end

                SEEK_LO: begin
                    if (ptr_q == addr_q) begin
                        if (is_wr_q) begin
                            mdopc_q <= OPC_WR;
                            mdwdi_q <= wdata_q;
                            state_q <= ACC_WR;
                        end else begin
                            mdopc_q <= OPC_RD;
                            state_q <= ACC_RD;
                        end
                    end else begin
                        mdainc_q <= 1'b1;
                        state_q  <= SEEK_HI;
                    end
                end

                ACC_WR: begin
                    mdopc_q     <= OPC_NOP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                    state_q     <= RESP;
                end

                ACC_RD: begin
                    mdopc_q <= OPC_NOP;
                    cnt_q   <= '0;
                    state_q <= RD_WAIT;
                end

                // mdrdo is valid RD_LAT cycles after the read opcode cycle
                RD_WAIT: begin
                    if (cnt_q == CW'(RD_LAT - 1)) begin
                        rsp_rdata_q <= mdrdo_i;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                APP_RST: begin
                    if (cnt_q == CW'(RST_CYCLES - 1)) begin
                        pll_reset_q <= 1'b0;
                        tcnt_q      <= '0;
                        state_q     <= APP_WAIT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                APP_WAIT: begin
                    if (lock_s_q) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_rdata_q <= '0;
                        state_q     <= RESP;
                    end else if (tcnt_q == TW'(LOCK_TIMEOUT - 1)) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        lock_err_q  <= 1'b1;
                        state_q     <= RESP;
                    end else if (tcnt_q != '1) begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end

                RESP: begin
                    if (resv_q) begin
                        resv_q      <= 1'b0;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end

                default: state_q <= INIT_RST;
            endcase
        end
    end

endmodule

// File: tb/tb_pll_drp_ctrl.sv
module tb_pll_drp_ctrl;
    localparam int RD_LAT       = 2;
    localparam int RST_CYCLES   = 16;
    localparam int LOCK_TIMEOUT = 65535;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_op;
    logic [5:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_err;
    logic [7:0] rsp_rdata;
    logic [1:0] mdopc;
    logic       mdainc;
    logic [7:0] mdwdi, mdrdo;
    logic       pll_reset, pll_lock, init_done, lock_err;

    int n_chk  = 0;
    int n_fail = 0;

    pll_drp_ctrl #(.RD_LAT(RD_LAT), .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .mdopc_o(mdopc), .mdainc_o(mdainc), .mdwdi_o(mdwdi), .mdrdo_i(mdrdo),
        .pll_reset_o(pll_reset), .pll_lock_i(pll_lock),
        .init_done_o(init_done), .lock_err_o(lock_err)
    );

    always #5 clk = ~clk;

    // PLL model: MDRP register file with auto-increment address, read data
    // valid RD_LAT cycles after the opcode, lock 10 cycles after reset falls.
    logic [7:0] mem [64];
    int mptr = 0, rd_cnt = 0, raddr = 0, lcnt = 0;
    int ainc_cnt = 0, opc_cnt = 0, rsp_cnt = 0;
    bit lock_en = 1'b1;

    always @(negedge clk) begin
        if (pll_reset) mptr = 0;
        else if (mdainc) begin mptr = (mptr + 1) % 64; ainc_cnt++; end
        if (mdopc != 2'b00) opc_cnt++;
        if (mdopc == 2'b01) mem[mptr] = mdwdi;
        if (rd_cnt > 0) begin
            rd_cnt--;
            mdrdo = (rd_cnt == 0) ? mem[raddr] : 8'hEE;
        end else mdrdo = 8'hEE;
        if (mdopc == 2'b10) begin rd_cnt = RD_LAT; raddr = mptr; end
        if (rsp_valid) rsp_cnt++;
        if (pll_reset) begin lcnt = 0; pll_lock = 1'b0; end
        else if (!lock_en) begin lcnt = 0; pll_lock = 1'b0; end
        else begin
            if (lcnt < 10) lcnt++;
            if (lcnt == 10) pll_lock = 1'b1;
        end
    end

    // Issue one command and wait (bounded) for its response. lat is cycles
    // from acceptance to rsp_valid, -1 if no response arrived.
    task automatic do_cmd(input logic [1:0] op, input logic [5:0] addr, input logic [7:0] wd,
                          input int bound, output int lat, output logic [7:0] rd, output logic er);
        int w;
        lat = -1; rd = '0; er = 1'b0; w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 300) begin @(negedge clk); w++; end
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wd;
        ainc_cnt = 0; opc_cnt = 0;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 1; k <= bound; k++) begin
            if (rsp_valid) begin lat = k; rd = rsp_rdata; er = rsp_err; break; end
            @(negedge clk);
        end
    endtask

    // From reset release: measure pll_reset width, then wait for init_done.
    task automatic wait_init(output int width);
        int w;
        width = 0; w = 0;
        while (!pll_reset && w < 10) begin @(negedge clk); w++; end
        while (pll_reset && width < 100) begin width++; @(negedge clk); end
        w = 0;
        while (!init_done && w < 200) begin @(negedge clk); w++; end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({cmd_ready, rsp_valid, mdopc, mdainc, pll_reset, init_done, lock_err, rsp_err} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0", {cmd_ready, rsp_valid, mdopc, mdainc, pll_reset, init_done, lock_err, rsp_err});
        end
        n_chk++;
        if ({mdwdi, rsp_rdata} !== 16'd0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0", {mdwdi, rsp_rdata});
        end
    endtask

    task automatic test_init();
        int width;
        rsp_cnt = 0;
        reset = 1'b0;
        wait_init(width);
        n_chk++;
        if (width !== RST_CYCLES) begin n_fail++; $display("FAIL init_rst_width: got %0d want %0d", width, RST_CYCLES); end
        n_chk++;
        if ({init_done, lock_err, cmd_ready} !== 3'b101) begin
            n_fail++; $display("FAIL init_flags: got %b want 101", {init_done, lock_err, cmd_ready});
        end
        n_chk++;
        if (rsp_cnt !== 0) begin n_fail++; $display("FAIL init_no_rsp: got %0d want 0", rsp_cnt); end
    endtask

    task automatic test_write_read();
        int lat; logic [7:0] rd; logic er;
        do_cmd(2'b01, 6'd5, 8'hA5, 300, lat, rd, er);
        n_chk++;
        if (lat !== 12) begin n_fail++; $display("FAIL wr5_lat: got %0d want 12", lat); end
        n_chk++;
        if (ainc_cnt !== 5) begin n_fail++; $display("FAIL wr5_ainc: got %0d want 5", ainc_cnt); end
        n_chk++;
        if ({er, rd, opc_cnt[3:0]} !== {1'b0, 8'h00, 4'd1}) begin
            n_fail++; $display("FAIL wr5_rsp: got err=%b rd=%h opc=%0d want 0 00 1", er, rd, opc_cnt);
        end
        @(negedge clk);
        n_chk++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rsp_one_cycle: got %b want 0", rsp_valid); end
        do_cmd(2'b00, 6'd5, 8'h00, 300, lat, rd, er);
        n_chk++;
        if (lat !== 2 + RD_LAT) begin n_fail++; $display("FAIL rd5_lat: got %0d want %0d", lat, 2 + RD_LAT); end
        n_chk++;
        if (ainc_cnt !== 0) begin n_fail++; $display("FAIL rd5_ainc: got %0d want 0", ainc_cnt); end
        n_chk++;
        if ({er, rd} !== {1'b0, 8'hA5}) begin n_fail++; $display("FAIL rd5_data: got %b %h want 0 a5", er, rd); end
        do_cmd(2'b01, 6'd6, 8'h3C, 300, lat, rd, er);
        n_chk++;
        if (lat !== 4) begin n_fail++; $display("FAIL wr6_lat: got %0d want 4", lat); end
        // 6 -> 5 is the longest seek: 63 steps
        do_cmd(2'b00, 6'd5, 8'h00, 300, lat, rd, er);
        n_chk++;
        if (lat !== 130) begin n_fail++; $display("FAIL rd5_far_lat: got %0d want 130", lat); end
        n_chk++;
        if ({ainc_cnt[7:0], rd} !== {8'd63, 8'hA5}) begin
            n_fail++; $display("FAIL rd5_far: got ainc=%0d rd=%h want 63 a5", ainc_cnt, rd);
        end
    endtask

    task automatic test_wrap();
        int lat; logic [7:0] rd; logic er;
        do_cmd(2'b01, 6'd2, 8'h5A, 300, lat, rd, er);
        n_chk++;
        if (lat !== 124) begin n_fail++; $display("FAIL wr2_lat: got %0d want 124", lat); end
        do_cmd(2'b01, 6'd60, 8'h77, 300, lat, rd, er);
        n_chk++;
        if (dut.ptr_q !== 6'd60) begin n_fail++; $display("FAIL ptr60: got %0d want 60", dut.ptr_q); end
        do_cmd(2'b00, 6'd2, 8'h00, 300, lat, rd, er);
        n_chk++;
        if (ainc_cnt !== 6) begin n_fail++; $display("FAIL wrap_ainc: got %0d want 6", ainc_cnt); end
        n_chk++;
        if (lat !== 16) begin n_fail++; $display("FAIL wrap_lat: got %0d want 16", lat); end
        n_chk++;
        if ({dut.ptr_q, rd, er} !== {6'd2, 8'h5A, 1'b0}) begin
            n_fail++; $display("FAIL wrap_rsp: got ptr=%0d rd=%h err=%b want 2 5a 0", dut.ptr_q, rd, er);
        end
    endtask

    task automatic test_reserved();
        int lat; logic [7:0] rd; logic er;
        do_cmd(2'b11, 6'd9, 8'hFF, 20, lat, rd, er);
        n_chk++;
        if (lat !== 2) begin n_fail++; $display("FAIL rsvd_lat: got %0d want 2", lat); end
        n_chk++;
        if ({er, rd} !== {1'b1, 8'h00}) begin n_fail++; $display("FAIL rsvd_rsp: got %b %h want 1 00", er, rd); end
        n_chk++;
        if ({ainc_cnt[3:0], opc_cnt[3:0]} !== 8'd0 || dut.ptr_q !== 6'd2) begin
            n_fail++; $display("FAIL rsvd_quiet: got ainc=%0d opc=%0d ptr=%0d want 0 0 2", ainc_cnt, opc_cnt, dut.ptr_q);
        end
    endtask

    task automatic test_apply();
        int lat; logic [7:0] rd; logic er;
        lock_en = 1'b1;
        do_cmd(2'b10, 6'd0, 8'h00, 300, lat, rd, er);
        n_chk++;
        if (lat < 26 || lat > 32) begin n_fail++; $display("FAIL apply_lat: got %0d want 26..32", lat); end
        n_chk++;
        if ({er, rd, dut.ptr_q, lock_err} !== 16'd0) begin
            n_fail++; $display("FAIL apply_rsp: got err=%b rd=%h ptr=%0d lerr=%b want 0", er, rd, dut.ptr_q, lock_err);
        end
    endtask

    task automatic test_apply_timeout();
        int lat; logic [7:0] rd; logic er;
        lock_en = 1'b0;
        do_cmd(2'b10, 6'd0, 8'h00, 70000, lat, rd, er);
        n_chk++;
        if (lat !== RST_CYCLES + LOCK_TIMEOUT + 1) begin
            n_fail++; $display("FAIL timeout_lat: got %0d want %0d", lat, RST_CYCLES + LOCK_TIMEOUT + 1);
        end
        n_chk++;
        if ({er, lock_err} !== 2'b11) begin n_fail++; $display("FAIL timeout_err: got %b want 11", {er, lock_err}); end
        lock_en = 1'b1;
        do_cmd(2'b00, 6'd0, 8'h00, 300, lat, rd, er);
        n_chk++;
        if ({lat[7:0], er, lock_err} !== {8'd4, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL lock_err_sticky: got lat=%0d err=%b lerr=%b want 4 0 1", lat, er, lock_err);
        end
    endtask

    task automatic test_reset_in_seek();
        int hi, w, width, lat; logic [7:0] rd; logic er;
        @(negedge clk);
        w = 0;
        while (!cmd_ready && w < 300) begin @(negedge clk); w++; end
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 6'd40; cmd_wdata = 8'h00;
        @(negedge clk);
        cmd_valid = 1'b0;
        hi = 0; w = 0;
        while (hi < 3 && w < 40) begin
            if (mdainc) hi++;
            if (hi < 3) begin @(negedge clk); w++; end
        end
        n_chk++;
        if (!(mdainc === 1'b1 && hi == 3)) begin n_fail++; $display("FAIL seek_reach: got hi=%0d mdainc=%b want 3 1", hi, mdainc); end
        reset = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({mdainc, mdopc, pll_reset, cmd_ready, init_done} !== 6'd0 || dut.ptr_q !== 6'd0) begin
            n_fail++; $display("FAIL seek_abort: got %b ptr=%0d want 0", {mdainc, mdopc, pll_reset, cmd_ready, init_done}, dut.ptr_q);
        end
        hi = 0;
        repeat (2) begin @(negedge clk); if (mdainc || mdopc != 2'b00) hi++; end
        n_chk++;
        if (hi !== 0) begin n_fail++; $display("FAIL seek_quiet: got %0d want 0", hi); end
        rsp_cnt = 0;
        reset = 1'b0;
        wait_init(width);
        n_chk++;
        if ({width[7:0], init_done, cmd_ready, rsp_cnt[3:0]} !== {8'd16, 1'b1, 1'b1, 4'd0}) begin
            n_fail++; $display("FAIL reinit: got width=%0d done=%b rdy=%b rsp=%0d want 16 1 1 0", width, init_done, cmd_ready, rsp_cnt);
        end
        do_cmd(2'b00, 6'd5, 8'h00, 300, lat, rd, er);
        n_chk++;
        if ({lat[7:0], rd} !== {8'd14, 8'hA5}) begin n_fail++; $display("FAIL post_reset_rd: got %0d %h want 14 a5", lat, rd); end
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_wdata = '0;
        mdrdo = '0; pll_lock = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        @(negedge clk);
        test_reset();
        test_init();
        test_write_read();
        test_wrap();
        test_reserved();
        test_apply();
        test_apply_timeout();
        test_reset_in_seek();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
